// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types and width helper for the round-robin select arbiter.
package rr_sel_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   // Bits needed to hold 'value'; never less than one.
   function automatic int clogb2(input int value);
      int w;
      w = 0;
      for (int v = value; v > 0; v = v >> 1) begin
         w++;
      end
      if (w == 0) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first request at or after ptr, wrapping.
module rr_prio_enc
   import rr_sel_arbiter_pkg::*;
#(
   parameter int SIZE = 10,
   parameter int SELW = clogb2(SIZE - 1)
) (
   input  logic [SIZE-1:0] req,
   input  logic [SELW-1:0] ptr,
   output logic            any,
   output logic [SELW-1:0] idx
);

   logic [2*SIZE-1:0] req2;
   logic [2*SIZE-1:0] masked;
   logic              found;

   // The upper copy supplies the wrapped part of the scan.
   always_comb begin
      req2   = {req, req};
      masked = '0;
      found  = 1'b0;
      idx    = '0;
      any    = |req;
      for (int j = 0; j < 2 * SIZE; j++) begin
         masked[j] = req2[j] && (j >= int'(ptr));
      end
      for (int j = 0; j < 2 * SIZE; j++) begin
         if (masked[j] && !found) begin
            found = 1'b1;
            idx   = (j >= SIZE) ? SELW'(j - SIZE) : SELW'(j);
         end
      end
   end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter with packet lock driving a crossbar output mux select.
module rr_sel_arbiter
   import rr_sel_arbiter_pkg::*;
#(
   parameter  int SIZE = 10,
   localparam int SELW = clogb2(SIZE - 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [SIZE-1:0] req,
   input  logic [SIZE-1:0] tail,
   input  logic            out_ready,
   output logic [SELW-1:0] sel,
   output logic            sel_valid,
   output logic [SIZE-1:0] grant,
   output logic [SIZE-1:0] ack
);

   arb_state_e      state_q, state_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [SIZE-1:0] grant_q, grant_d;
   logic            any;
   logic [SELW-1:0] win;
   logic            xfer;
   logic            last;

   rr_prio_enc #(
      .SIZE (SIZE),
      .SELW (SELW)
   ) u_enc (
      .req (req),
      .ptr (ptr_q),
      .any (any),
      .idx (win)
   );

   // Masking with the one-hot grant keeps unselected X inputs out.
   assign xfer = (state_q == ST_LOCKED) & (|(req & grant_q)) & out_ready;
   assign last = |(tail & grant_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any) begin
               state_d = ST_LOCKED;
               sel_d   = win;
               grant_d = SIZE'(1) << win;
            end
         end
         ST_LOCKED: begin
            if (xfer && last) begin
               state_d = ST_IDLE;
               grant_d = '0;
               ptr_d   = (sel_q == SELW'(SIZE - 1)) ? '0 : sel_q + SELW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = (state_q == ST_LOCKED);
   assign grant     = grant_q;
   assign ack       = grant_q & {SIZE{xfer}};

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter at SIZE=4 and SIZE=5 against a packet-level model.
module tb_rr_sel_arbiter;
   import rr_sel_arbiter_pkg::*;

   localparam int SW4 = clogb2(3);
   localparam int SW5 = clogb2(4);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst4 = 1'b1, rdy4 = 1'b1;
   logic [3:0]     req4 = '0, tail4 = '0;
   logic [SW4-1:0] sel4;
   logic           sv4;
   logic [3:0]     grant4, ack4;

   logic           rst5 = 1'b1, rdy5 = 1'b1;
   logic [4:0]     req5 = '0, tail5 = '0;
   logic [SW5-1:0] sel5;
   logic           sv5;
   logic [4:0]     grant5, ack5;

   rr_sel_arbiter #(.SIZE(4)) dut4 (
      .clock(clk), .reset(rst4), .req(req4), .tail(tail4),
      .out_ready(rdy4), .sel(sel4), .sel_valid(sv4),
      .grant(grant4), .ack(ack4)
   );

   rr_sel_arbiter #(.SIZE(5)) dut5 (
      .clock(clk), .reset(rst5), .req(req5), .tail(tail5),
      .out_ready(rdy5), .sel(sel5), .sel_valid(sv5),
      .grant(grant5), .ack(ack5)
   );

   int checks = 0;
   int failures = 0;

   // Packet-level model: who owns the output, where the next scan starts.
   int m_lock[2] = '{0, 0};
   int m_own[2]  = '{0, 0};
   int m_ptr[2]  = '{0, 0};
   int m_sel[2]  = '{0, 0};

   task automatic cmp(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %0s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic mstep(input int m, input logic rst, input logic [4:0] rq,
                        input logic [4:0] tl, input logic rdy);
      int n;
      int c;
      bit found;
      n = (m == 0) ? 4 : 5;
      if (rst) begin
         m_lock[m] = 0;
         m_ptr[m]  = 0;
         m_sel[m]  = 0;
      end else if (m_lock[m] == 0) begin
         if (rq != 0) begin
            found = 0;
            for (int k = 0; k < n; k++) begin
               c = (m_ptr[m] + k) % n;
               if (!found && rq[c]) begin
                  found = 1;
                  m_own[m] = c;
               end
            end
            m_lock[m] = 1;
            m_sel[m]  = m_own[m];
         end
      end else if (rq[m_own[m]] && rdy && tl[m_own[m]]) begin
         m_lock[m] = 0;
         m_ptr[m]  = (m_own[m] + 1) % n;
      end
   endtask

   always @(posedge clk) begin
      mstep(0, rst4, {1'b0, req4}, {1'b0, tail4}, rdy4);
      mstep(1, rst5, req5, tail5, rdy5);
   end

   function automatic int mgrant(input int m);
      return (m_lock[m] != 0) ? (1 << m_own[m]) : 0;
   endfunction

   function automatic int mack(input int m, input logic [4:0] rq,
                               input logic rdy);
      return (m_lock[m] != 0 && rq[m_own[m]] && rdy) ? (1 << m_own[m]) : 0;
   endfunction

   task automatic chk4();
      cmp("m4_valid", 32'(sv4), m_lock[0]);
      cmp("m4_sel", 32'(sel4), m_sel[0]);
      cmp("m4_grant", 32'(grant4), mgrant(0));
      cmp("m4_ack", 32'(ack4), mack(0, {1'b0, req4}, rdy4));
   endtask

   task automatic chk5();
      cmp("m5_valid", 32'(sv5), m_lock[1]);
      cmp("m5_sel", 32'(sel5), m_sel[1]);
      cmp("m5_grant", 32'(grant5), mgrant(1));
      cmp("m5_ack", 32'(ack5), mack(1, req5, rdy5));
      cmp("m5_sel_range", 32'(sel5 <= 3'd4), 1);
   endtask

   task automatic drive4(input logic r, input logic [3:0] rq,
                         input logic [3:0] tl, input logic rdy);
      rst4 = r; req4 = rq; tail4 = tl; rdy4 = rdy;
   endtask

   task automatic drive5(input logic r, input logic [4:0] rq,
                         input logic [4:0] tl, input logic rdy);
      rst5 = r; req5 = rq; tail5 = tl; rdy5 = rdy;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] tail;
      logic       rdy;
      logic       sv;
      int         sel;
      logic [3:0] grant;
      logic [3:0] ack;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(input logic r, input logic [3:0] rq,
                               input logic [3:0] tl, input logic rdy,
                               input logic sv, input int s,
                               input logic [3:0] g, input logic [3:0] a);
      vec_t v;
      v.rst = r; v.req = rq; v.tail = tl; v.rdy = rdy;
      v.sv = sv; v.sel = s; v.grant = g; v.ack = a;
      return v;
   endfunction

   initial begin
      for (int i = 0; i < 5; i++) tbl[i] = mk(0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 4'h0);
      tbl[5]  = mk(0, 4'h5, 4'h0, 1, 0, 0, 4'h0, 4'h0);
      tbl[6]  = mk(0, 4'h5, 4'h0, 1, 1, 0, 4'h1, 4'h1);
      tbl[7]  = mk(0, 4'h5, 4'h0, 1, 1, 0, 4'h1, 4'h1);
      tbl[8]  = mk(0, 4'h5, 4'h1, 1, 1, 0, 4'h1, 4'h1);
      tbl[9]  = mk(0, 4'h4, 4'h4, 1, 0, 0, 4'h0, 4'h0);
      tbl[10] = mk(0, 4'h4, 4'h4, 1, 1, 2, 4'h4, 4'h4);
      tbl[11] = mk(0, 4'h0, 4'h0, 1, 0, 2, 4'h0, 4'h0);
      tbl[12] = mk(1, 4'h0, 4'h0, 1, 0, 2, 4'h0, 4'h0);
      tbl[13] = mk(0, 4'hF, 4'hF, 1, 0, 0, 4'h0, 4'h0);
      tbl[14] = mk(0, 4'hF, 4'hF, 1, 1, 0, 4'h1, 4'h1);
      tbl[15] = mk(0, 4'hF, 4'hF, 1, 0, 0, 4'h0, 4'h0);
      tbl[16] = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'h2, 4'h2);
      tbl[17] = mk(0, 4'hF, 4'hF, 1, 0, 1, 4'h0, 4'h0);
      tbl[18] = mk(0, 4'hF, 4'hF, 1, 1, 2, 4'h4, 4'h4);
      tbl[19] = mk(0, 4'hF, 4'hF, 1, 0, 2, 4'h0, 4'h0);
      tbl[20] = mk(0, 4'hF, 4'hF, 1, 1, 3, 4'h8, 4'h8);
      tbl[21] = mk(0, 4'hF, 4'hF, 1, 0, 3, 4'h0, 4'h0);
      tbl[22] = mk(0, 4'h0, 4'h0, 1, 1, 0, 4'h1, 4'h0);
      tbl[23] = mk(0, 4'h1, 4'h1, 1, 1, 0, 4'h1, 4'h1);
      tbl[24] = mk(0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 4'h0);

      // Reset both instances.
      drive4(1, 4'h0, 4'h0, 1);
      drive5(1, 5'h0, 5'h0, 1);
      next();
      next();
      drive5(0, 5'h0, 5'h0, 1);

      // Idle, two-packet handoff, 4-way rotation, bubble on req drop.
      for (int i = 0; i < 25; i++) begin
         drive4(tbl[i].rst, tbl[i].req, tbl[i].tail, tbl[i].rdy);
         @(negedge clk);
         cmp($sformatf("t%0d_valid", i), 32'(sv4), 32'(tbl[i].sv));
         cmp($sformatf("t%0d_sel", i), 32'(sel4), tbl[i].sel);
         cmp($sformatf("t%0d_grant", i), 32'(grant4), 32'(tbl[i].grant));
         cmp($sformatf("t%0d_ack", i), 32'(ack4), 32'(tbl[i].ack));
         next();
      end

      // Stall while locked on input 1; input 3 arrives mid-stall.
      drive4(0, 4'b0010, 4'b0000, 1);
      @(negedge clk); chk4(); next();
      for (int k = 0; k < 4; k++) begin
         drive4(0, (k >= 1) ? 4'b1010 : 4'b0010, 4'b0000, 0);
         @(negedge clk); chk4();
         cmp("stall_ack", 32'(ack4), 0);
         cmp("stall_sel", 32'(sel4), 1);
         cmp("stall_grant", 32'(grant4), 32'h2);
         next();
      end
      drive4(0, 4'b1010, 4'b0010, 1);
      @(negedge clk); chk4();
      cmp("stall_release_ack", 32'(ack4), 32'h2);
      next();
      drive4(0, 4'b1000, 4'b1000, 1);
      @(negedge clk); chk4();
      cmp("post_stall_bubble", 32'(sv4), 0);
      next();
      @(negedge clk); chk4();
      cmp("late_req_sel", 32'(sel4), 3);
      cmp("late_req_ack", 32'(ack4), 32'h8);
      next();

      // Reset mid-packet while locked on input 2.
      drive4(0, 4'b0100, 4'b0000, 1);
      @(negedge clk); chk4(); next();
      @(negedge clk); chk4();
      cmp("mid_pkt_ack", 32'(ack4), 32'h4);
      next();
      drive4(1, 4'b0100, 4'b0000, 1);
      @(negedge clk); chk4(); next();
      drive4(0, 4'b0100, 4'b0000, 1);
      @(negedge clk); chk4();
      cmp("rst_drop_valid", 32'(sv4), 0);
      cmp("rst_drop_grant", 32'(grant4), 0);
      cmp("rst_drop_ack", 32'(ack4), 0);
      next();
      @(negedge clk); chk4();
      cmp("regrant_sel", 32'(sel4), 2);
      cmp("regrant_valid", 32'(sv4), 1);
      next();
      drive4(0, 4'b0100, 4'b0100, 1);
      @(negedge clk); chk4(); next();

      // Random traffic against the model at SIZE=4.
      for (int i = 0; i < 2000; i++) begin
         drive4(($urandom % 64) == 0, 4'($urandom), 4'($urandom),
                ($urandom % 4) != 0);
         @(negedge clk); chk4(); next();
      end
      drive4(0, 4'h0, 4'h0, 1);

      // SIZE=5: drive ptr to 4, then wrap it back to 0.
      drive5(0, 5'b01000, 5'b01000, 1);
      @(negedge clk); chk5(); next();
      @(negedge clk); chk5();
      cmp("s5_first_ack", 32'(ack5), 32'h08);
      next();
      drive5(0, 5'b10001, 5'b10001, 1);
      @(negedge clk); chk5();
      cmp("s5_bubble", 32'(sv5), 0);
      next();
      @(negedge clk); chk5();
      cmp("s5_sel_top", 32'(sel5), 4);
      cmp("s5_ack_top", 32'(ack5), 32'h10);
      next();
      @(negedge clk); chk5(); next();
      @(negedge clk); chk5();
      cmp("s5_wrap_sel", 32'(sel5), 0);
      next();

      for (int i = 0; i < 10000; i++) begin
         drive5(($urandom % 128) == 0, 5'($urandom), 5'($urandom),
                ($urandom % 4) != 0);
         @(negedge clk); chk5(); next();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Round-robin arbiter with packet lock that produces the encoded select for the N-to-1 crossbar output mux in the dart32_8x8 router.
- Arbitrates among SIZE input requesters and holds the grant from the head flit through the tail flit of the winning packet.
- Its `sel` output drives the mux select directly.
- Its one-hot `ack` output pops the winning input buffer.

Parameters:
- SIZE, 10, number of requesters; must match the SIZE of the downstream mux.
- SELW, CLogB2(SIZE-1), width of the encoded select; derived parameter, never overridden.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  SIZE  per-input request; a flit is available at input i.
- tail  input  SIZE  per-input flag; the flit currently offered at input i is the packet tail. Only meaningful where req is set.
- out_ready  input  1  downstream (output port / link) can accept a flit this cycle.
- sel  output  SELW  encoded index of the granted input; registered.
- sel_valid  output  1  a grant is held and sel is meaningful; registered.
- grant  output  SIZE  one-hot of the held grant; registered; all zero when sel_valid=0.
- ack  output  SIZE  combinational: grant & {SIZE{xfer}}, one-hot flit-accepted strobe back to the inputs.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE, ptr=0, sel=0, sel_valid=0, grant=0.
  - ack=0, since grant=0.
  - Reset asserted mid-packet drops the lock at the next edge; no ack is produced in the reset cycle's aftermath.
- xfer = sel_valid & req[sel] & out_ready. This is the only transfer condition.
- States:
  - IDLE: sel_valid=0.
    - If |req at an edge: winner = first i with req[i]=1, scanning ptr, ptr+1, ..., SIZE-1, 0, ..., ptr-1.
    - Next state LOCKED; sel<=winner, grant<=onehot(winner), sel_valid<=1.
    - If req=0: stay IDLE; sel holds its last value.
  - LOCKED: sel_valid=1.
    - On xfer with tail[sel]=1: next state IDLE; sel_valid<=0, grant<=0; ptr<=sel+1, wrapping to 0 when sel==SIZE-1; sel holds.
    - On xfer with tail[sel]=0: stay LOCKED; the grant is held.
    - With no xfer (req[sel]=0 bubble, or out_ready=0): stay LOCKED; nothing changes.
- Latency:
  - Request to sel_valid: 1 cycle.
  - First ack can fire in the first cycle sel_valid=1.
  - One mandatory IDLE cycle between consecutive packets, i.e. one bubble per packet.
- Single-flit packet: head flit has tail=1; it is acked and the lock is released in the same cycle.
- Requests from other inputs while LOCKED are ignored; no preemption.
- A requester whose req drops while not granted simply loses its turn; there is no request memory.
- ptr advances only on packet completion, never on grant. Fairness is therefore per packet.
- sel is always < SIZE. Non-power-of-2 SIZE must never produce an out-of-range sel.
- No X on outputs after reset; req/tail may be X only when not selected.

Decomposition:
- Shared include math.v supplies CLogB2 for SELW; nothing else shared.
- One natural sub-module: rr_prio_enc (combinational).
  - Inputs: req[SIZE], ptr[SELW].
  - Outputs: any, idx[SELW].
  - Implemented as double-width masked find-first-set so the scan wraps.
- FSM, ptr and output registers live in rr_sel_arbiter.

Test Plan (SIZE=4, SELW=2 unless noted):
- Reset, then req=0000 for 5 cycles -> sel_valid=0, grant=0000, ack=0000 throughout.
- req=0101, ptr=0, out_ready=1, 3-flit packet on input 0 (tail on 3rd) -> sel=0 one cycle after req; ack=0001 for 3 cycles; IDLE one cycle; then input 2 granted (sel=2), ptr=1 after the first packet.
- All req=1111, single-flit packets, out_ready=1 -> grant order 0,1,2,3,0,... each with one bubble cycle; ptr wraps 3->0.
- Locked on input 1, out_ready=0 for 4 cycles, then 1 with tail -> ack=0000 while stalled, sel stays 1, ack=0010 on release; req[3] raised mid-stall is not granted until after release.
- Locked on input 2 mid-packet, reset asserted one cycle -> next cycle sel_valid=0, grant=0000, ptr=0; with req=0100 held, re-grant of input 2 one cycle after reset deasserts.
- SIZE=5 (SELW=3), req=10000, ptr=4 -> sel=4; after its tail, ptr=0; sel never exceeds 4 under random req/tail/out_ready for 10k cycles.
